// File: rtl/keccak_msg_feeder.sv
// -----------------------------------------------------------------------------
// keccak_msg_feeder
//
// Host-side transmitter for the keccak core's word input. Takes a message as a
// byte stream (valid/ready), packs bytes big-endian into 32-bit words, hands
// them to the core honouring buffer_full back-pressure, applies the core's
// final-word rules (is_last / byte_num, extra zero word for 4-byte-aligned
// messages), then waits for the digest and pulses done.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high, clears all state
//   s_data/s_valid/s_last/s_ready   byte stream in (accept on s_valid&&s_ready)
//   core_clear     one-cycle pulse before each message, ORed into core reset
//   k_in           word to core, byte 0 in [31:24]
//   k_in_ready     k_in valid
//   k_is_last      current word is the final word
//   k_byte_num     valid bytes in the final word (0..3)
//   k_buffer_full  core cannot take a word this cycle
//   k_out_ready    core digest valid (level)
//   busy           high from leaving IDLE through the done cycle
//   done           one-cycle pulse once the digest is valid
// -----------------------------------------------------------------------------
module keccak_msg_feeder (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic        core_clear,
    output logic [31:0] k_in,
    output logic        k_in_ready,
    output logic        k_is_last,
    output logic [1:0]  k_byte_num,
    input  logic        k_buffer_full,
    input  logic        k_out_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLEAR     = 3'd1,
        ST_PACK      = 3'd2,
        ST_SEND      = 3'd3,
        ST_SEND_LAST = 3'd4,
        ST_WAIT_HASH = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_cnt;
    logic [1:0]  w_cnt_next;
    logic [31:0] r_word;
    logic [31:0] w_word_next;
    logic [1:0]  r_byte_num;
    logic [1:0]  w_byte_num_next;
    logic        r_pad_pending;
    logic        w_pad_next;

    logic        r_s_ready;
    logic        r_core_clear;
    logic        r_k_in_ready;
    logic        r_k_is_last;
    logic        r_busy;
    logic        r_done;

    // Places byte b at big-endian index idx; index 0 starts a fresh word so
    // the bytes not yet written read as zero.
    function automatic logic [31:0] f_insert_byte(
        input logic [31:0] word,
        input logic [1:0]  idx,
        input logic [7:0]  b
    );
        logic [31:0] res;
        res = word;
        case (idx)
            2'd0:    res = {b, 24'h000000};
            2'd1:    res[23:16] = b;
            2'd2:    res[15:8]  = b;
            2'd3:    res[7:0]   = b;
            default: res = word;
        endcase
        return res;
    endfunction

    // Next-state and datapath update for the message sequencer.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_word_next     = r_word;
        w_byte_num_next = r_byte_num;
        w_pad_next      = r_pad_pending;
        case (r_state)
            ST_IDLE: begin
                // The first byte only triggers the clear; it is taken in PACK.
                if (s_valid) begin
                    w_state_next = ST_CLEAR;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                w_state_next    = ST_PACK;
                w_cnt_next      = 2'd0;
                w_word_next     = 32'h0000_0000;
                w_byte_num_next = 2'd0;
                w_pad_next      = 1'b0;
            end
            ST_PACK: begin
                // s_ready is high for the whole of PACK, so s_valid is an accept.
                if (s_valid) begin
                    w_word_next = f_insert_byte(r_word, r_cnt, s_data);
                    if (s_last) begin
                        w_cnt_next = 2'd0;
                        if (r_cnt == 2'd3) begin
                            // Full final word: core never sees is_last with 4
                            // bytes, so an empty closing word follows.
                            w_state_next = ST_SEND;
                            w_pad_next   = 1'b1;
                        end else begin
                            w_state_next    = ST_SEND_LAST;
                            w_byte_num_next = r_cnt + 2'd1;
                        end
                    end else if (r_cnt == 2'd3) begin
                        w_state_next = ST_SEND;
                        w_cnt_next   = 2'd0;
                    end else begin
                        w_cnt_next = r_cnt + 2'd1;
                    end
                end else begin
                    w_state_next = ST_PACK;
                end
            end
            ST_SEND: begin
                if (!k_buffer_full) begin
                    if (r_pad_pending) begin
                        w_state_next    = ST_SEND_LAST;
                        w_word_next     = 32'h0000_0000;
                        w_byte_num_next = 2'd0;
                        w_pad_next      = 1'b0;
                    end else begin
                        w_state_next = ST_PACK;
                    end
                end else begin
                    w_state_next = ST_SEND;
                end
            end
            ST_SEND_LAST: begin
                if (!k_buffer_full) begin
                    w_state_next    = ST_WAIT_HASH;
                    w_word_next     = 32'h0000_0000;
                    w_byte_num_next = 2'd0;
                end else begin
                    w_state_next = ST_SEND_LAST;
                end
            end
            ST_WAIT_HASH: begin
                if (k_out_ready) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_WAIT_HASH;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next    = ST_IDLE;
                w_cnt_next      = 2'd0;
                w_word_next     = 32'h0000_0000;
                w_byte_num_next = 2'd0;
                w_pad_next      = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 2'd0;
            r_word        <= 32'h0000_0000;
            r_byte_num    <= 2'd0;
            r_pad_pending <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_word        <= w_word_next;
            r_byte_num    <= w_byte_num_next;
            r_pad_pending <= w_pad_next;
        end
    end

    // Control outputs registered from the next state, so each one equals a
    // decode of the current state with no path from any input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s_ready    <= 1'b0;
            r_core_clear <= 1'b0;
            r_k_in_ready <= 1'b0;
            r_k_is_last  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_s_ready    <= (w_state_next == ST_PACK);
            r_core_clear <= (w_state_next == ST_CLEAR);
            r_k_in_ready <= (w_state_next == ST_SEND) || (w_state_next == ST_SEND_LAST);
            r_k_is_last  <= (w_state_next == ST_SEND_LAST);
            r_busy       <= (w_state_next != ST_IDLE);
            r_done       <= (w_state_next == ST_DONE);
        end
    end

    assign s_ready    = r_s_ready;
    assign core_clear = r_core_clear;
    assign k_in       = r_word;
    assign k_in_ready = r_k_in_ready;
    assign k_is_last  = r_k_is_last;
    assign k_byte_num = r_byte_num;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_keccak_msg_feeder.sv
// -----------------------------------------------------------------------------
// Testbench for keccak_msg_feeder: directed message table, mid-message reset,
// back-to-back messages with a stale digest flag, and random messages with
// random source gaps and core back-pressure, checked against a word-level
// model of the expected core transfers.
// -----------------------------------------------------------------------------
module tb_keccak_msg_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic        core_clear;
    logic [31:0] k_in;
    logic        k_in_ready;
    logic        k_is_last;
    logic [1:0]  k_byte_num;
    logic        k_buffer_full;
    logic        k_out_ready;
    logic        busy;
    logic        done;

    keccak_msg_feeder dut (
        .clk           (clk),
        .reset         (reset),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_last        (s_last),
        .s_ready       (s_ready),
        .core_clear    (core_clear),
        .k_in          (k_in),
        .k_in_ready    (k_in_ready),
        .k_is_last     (k_is_last),
        .k_byte_num    (k_byte_num),
        .k_buffer_full (k_buffer_full),
        .k_out_ready   (k_out_ready),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        logic        last;
        logic [1:0]  bn;
    } xfer_t;

    typedef struct {
        int          stall_at;
        logic [31:0] last_w;
        logic [1:0]  last_bn;
        int          xfers;
        int          span;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [7:0]  tx_q[$];
    xfer_t       exp_q[$];
    int          n_xfer = 0;
    int          clr_cnt = 0;
    int          done_cnt = 0;
    bit          in_msg = 1'b0;
    bit          got_last = 1'b0;
    bit          prev_out_ready = 1'b0;
    logic [31:0] last_word = 32'd0;
    logic [1:0]  last_bn = 2'd0;
    int          last_xfer_cyc = 0;
    int          first_acc_cyc = 0;
    int          stall_at = -1;
    int          stall_rem = 0;
    int          hash_cd = 0;
    int          hash_delay = 3;
    bit          stall_done = 1'b0;
    bit          rand_stall = 1'b0;
    bit          stale_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic load_str(input string s);
        tx_q.delete();
        for (int i = 0; i < s.len(); i++) tx_q.push_back(s[i]);
    endtask

    // Reference: whole words of 4 bytes, then a closing word holding the
    // n%4 leftover bytes (zero word when the length is a multiple of 4).
    task automatic model_push();
        int          n;
        int          nfull;
        int          rem;
        logic [31:0] w;
        n     = tx_q.size();
        nfull = n / 4;
        rem   = n % 4;
        for (int i = 0; i < nfull; i++) begin
            w = {tx_q[4*i], tx_q[4*i+1], tx_q[4*i+2], tx_q[4*i+3]};
            exp_q.push_back('{w, 1'b0, 2'd0});
        end
        w = 32'd0;
        for (int k = 0; k < rem; k++) w = w | ({24'd0, tx_q[4*nfull+k]} << (24 - 8*k));
        exp_q.push_back('{w, 1'b1, 2'(rem)});
    endtask

    task automatic start_msg();
        exp_q.delete();
        n_xfer   = 0;
        clr_cnt  = 0;
        done_cnt = 0;
        got_last = 1'b0;
    endtask

    task automatic send_bytes(input int n_send, input bit gaps, input bit hold, input bit chk_lat);
        int c0;
        bit acc;
        @(posedge clk);
        #1;
        c0 = cyc;
        for (int i = 0; i < n_send; i++) begin
            if (gaps && i > 0 && $urandom_range(0, 2) == 0) begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
                s_last  = 1'($urandom);
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            s_valid = 1'b1;
            s_data  = tx_q[i];
            s_last  = (i == tx_q.size() - 1);
            acc = 1'b0;
            for (int t = 0; t < 300 && !acc; t++) begin
                @(negedge clk);
                if (s_ready) acc = 1'b1;
                @(posedge clk);
                #1;
            end
            check("byte_accept", 32'(acc), 32'd1);
            if (i == 0) begin
                first_acc_cyc = cyc;
                if (chk_lat) check("start_latency", first_acc_cyc - c0, 32'd3);
            end
        end
        if (!hold) begin
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic wait_done(input int target);
        for (int t = 0; t < 3000 && done_cnt < target; t++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("done_count", done_cnt, target);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_k_in"}, k_in, 32'd0);
        check({tag, "_flags"},
              32'({s_ready, core_clear, k_in_ready, k_is_last, k_byte_num, busy, done}), 32'd0);
    endtask

    // Core model: back-pressure and digest-valid, driven just after each edge.
    initial begin
        k_buffer_full = 1'b0;
        k_out_ready   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                k_buffer_full = 1'b0;
                k_out_ready   = 1'b0;
                hash_cd       = 0;
                stall_rem     = 0;
            end else begin
                if (stall_rem > 0) begin
                    k_buffer_full = 1'b1;
                    stall_rem--;
                end else if (k_in_ready && !stall_done && stall_at >= 0 && n_xfer == stall_at) begin
                    stall_done    = 1'b1;
                    stall_rem     = 4;
                    k_buffer_full = 1'b1;
                end else begin
                    k_buffer_full = rand_stall ? ($urandom_range(0, 2) == 0) : 1'b0;
                end
                if (core_clear && !stale_mode) k_out_ready = 1'b0;
                if (hash_cd > 0) begin
                    hash_cd--;
                    k_out_ready = (hash_cd == 0);
                end
            end
        end
    end

    // Monitor on the falling edge: checks every presented word and the
    // clear/busy/done sequencing.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("busy", 32'(busy), 32'(in_msg || core_clear));
                if (core_clear) begin
                    check("clear_outside_msg", 32'(in_msg), 32'd0);
                    in_msg   = 1'b1;
                    got_last = 1'b0;
                    clr_cnt++;
                end
                if (k_in_ready) begin
                    if (n_xfer < exp_q.size()) begin
                        check("k_in", k_in, exp_q[n_xfer].w);
                        check("k_is_last", 32'(k_is_last), 32'(exp_q[n_xfer].last));
                        if (exp_q[n_xfer].last) check("k_byte_num", 32'(k_byte_num), 32'(exp_q[n_xfer].bn));
                    end else begin
                        check("xfer_count", n_xfer, exp_q.size());
                    end
                    if (!k_buffer_full) begin
                        if (k_is_last) begin
                            got_last = 1'b1;
                            hash_cd  = hash_delay;
                        end
                        last_word     = k_in;
                        last_bn       = k_byte_num;
                        last_xfer_cyc = cyc + 1;
                        n_xfer++;
                    end
                end else begin
                    check("idle_word_flags", 32'({k_is_last, k_byte_num}), 32'd0);
                end
                if (done) begin
                    check("done_after_hash", 32'({got_last, prev_out_ready}), 32'd3);
                    done_cnt++;
                    in_msg = 1'b0;
                end
                prev_out_ready = k_out_ready;
            end
        end
    end

    initial begin
        vec_t  vecs[5];
        string vmsg[5];
        int    len;

        vmsg[0] = "Hello, world!";
        vecs[0] = '{-1, 32'h21000000, 2'd1, 4, 16};
        vmsg[1] = "Hello, world";
        vecs[1] = '{-1, 32'h00000000, 2'd0, 4, 15};
        vmsg[2] = "The quick brown fox jumps over the lazy dog";
        vecs[2] = '{4, 32'h646F6700, 2'd3, 11, 58};
        vmsg[3] = "A";
        vecs[3] = '{-1, 32'h41000000, 2'd1, 1, 1};
        vmsg[4] = "abc";
        vecs[4] = '{-1, 32'h61626300, 2'd3, 1, 3};

        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'd0;
        s_last  = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_all_zero("reset");
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Reset after 6 bytes: one word already sent, partial word dropped.
        hash_delay = 3;
        load_str("Hello, world");
        start_msg();
        model_push();
        send_bytes(6, 1'b0, 1'b0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        check("xfers_before_reset", n_xfer, 32'd1);
        in_msg = 1'b0;
        start_msg();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        check("xfers_after_reset", n_xfer, 32'd0);

        // Directed message table.
        for (int v = 0; v < 5; v++) begin
            load_str(vmsg[v]);
            start_msg();
            model_push();
            stall_at   = vecs[v].stall_at;
            stall_done = 1'b0;
            rand_stall = 1'b0;
            stale_mode = 1'b0;
            hash_delay = 2 + v;
            send_bytes(tx_q.size(), 1'b0, 1'b0, 1'b1);
            wait_done(1);
            check($sformatf("xfers[%0d]", v), n_xfer, vecs[v].xfers);
            check($sformatf("last_word[%0d]", v), last_word, vecs[v].last_w);
            check($sformatf("last_bn[%0d]", v), 32'(last_bn), 32'(vecs[v].last_bn));
            check($sformatf("clears[%0d]", v), clr_cnt, 32'd1);
            check($sformatf("span[%0d]", v), last_xfer_cyc - first_acc_cyc, vecs[v].span);
        end
        stall_at = -1;

        // Back-to-back, s_valid held; digest flag left high into message 2.
        start_msg();
        hash_delay = 4;
        tx_q.delete();
        for (int i = 0; i < 6; i++) tx_q.push_back(8'($urandom));
        model_push();
        send_bytes(6, 1'b0, 1'b1, 1'b1);
        stale_mode = 1'b1;
        tx_q.delete();
        for (int i = 0; i < 9; i++) tx_q.push_back(8'($urandom));
        model_push();
        send_bytes(9, 1'b0, 1'b0, 1'b0);
        wait_done(2);
        check("b2b_xfers", n_xfer, exp_q.size());
        check("b2b_clears", clr_cnt, 32'd2);
        stale_mode = 1'b0;

        // Random messages with source gaps and random back-pressure.
        for (int r = 0; r < 12; r++) begin
            start_msg();
            tx_q.delete();
            len = $urandom_range(1, 33);
            for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom));
            model_push();
            rand_stall = 1'b1;
            hash_delay = $urandom_range(1, 6);
            send_bytes(len, 1'b1, 1'b0, 1'b1);
            wait_done(1);
            check($sformatf("rand_xfers[%0d]", r), n_xfer, exp_q.size());
            check($sformatf("rand_clears[%0d]", r), clr_cnt, 32'd1);
        end
        rand_stall = 1'b0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keccak_msg_feeder.md
# keccak_msg_feeder

Host-side transmitter for the `keccak` core's word input interface. It accepts a message as a byte stream with valid/ready handshake and packs the bytes big-endian into 32-bit words. It drives the core's `in`/`in_ready`/`is_last`/`byte_num` signals, honours `buffer_full` back-pressure and applies the core's final-word padding rules. It then waits for `out_ready` and pulses `done`. It sits between a byte-oriented source (UART, DMA, register FIFO) and `keccak`.

## Interface
Parameters: none.

Ports:
- `clk` input 1: single clock, all logic rising-edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `s_data` input 8: message byte.
- `s_valid` input 1: `s_data` valid.
- `s_last` input 1: qualifies `s_data` as final byte of message.
- `s_ready` output 1: byte accepted on cycle where `s_valid && s_ready`.
- `core_clear` output 1: one-cycle pulse, ORed into `keccak` `reset` before each message.
- `k_in` output 32: word to core; byte 0 in [31:24].
- `k_in_ready` output 1: `k_in` valid.
- `k_is_last` output 1: current word is final word.
- `k_byte_num` output 2: valid bytes in final word (0..3); don't-care unless `k_is_last`.
- `k_buffer_full` input 1: core cannot accept a word this cycle.
- `k_out_ready` input 1: core digest valid (level).
- `busy` output 1: high from leaving IDLE until `done`.
- `done` output 1: one-cycle pulse when digest valid.

## Operation
- Word transfer: occurs on a rising edge where `k_in_ready=1` and `k_buffer_full=0`. While `k_buffer_full=1`, hold `k_in`, `k_is_last` and `k_byte_num` stable, with `k_in_ready` high.
- Packing: byte index j (0..3) within a word goes to `k_in[31-8j -: 8]`. Unfilled bytes are 0.
- State machine:
  - IDLE -> CLEAR when `s_valid=1`. The byte is not consumed; `s_ready=0`.
  - CLEAR: `core_clear=1` for exactly one cycle, then -> PACK.
  - PACK: `s_ready=1`, which is the only state where it is high.
    - On an accepted byte, store it at index `cnt`.
    - If the byte is not last and `cnt==3`, -> SEND and set `cnt=0`.
    - If the byte is last and `cnt<3`, -> SEND_LAST with `k_byte_num=cnt+1`.
    - If the byte is last and `cnt==3`, -> SEND with `pad_pending=1`.
    - Otherwise `cnt++`.
  - SEND: present the full word with `k_is_last=0`. On transfer:
    - if `pad_pending`, -> SEND_LAST with word 0x00000000 and `k_byte_num=0`;
    - else -> PACK.
  - SEND_LAST: `k_is_last=1`. On transfer -> WAIT_HASH; `k_in_ready`, `k_is_last` and `k_byte_num` drop to 0 next cycle.
  - WAIT_HASH: when `k_out_ready=1` -> DONE.
  - DONE: `done=1` for one cycle, `busy` falls, -> IDLE.
- Messages whose length is a multiple of 4 always produce an extra all-zero final word with `byte_num=0`. The core never sees `is_last` with 4 valid bytes.
- Empty messages are not supported. The first byte of every message starts a new CLEAR.
- `s_last` is ignored unless `s_valid && s_ready`.

## Timing
- Reset values: `s_ready=0`, `core_clear=0`, `k_in=0`, `k_in_ready=0`, `k_is_last=0`, `k_byte_num=0`, `busy=0`, `done=0`, state IDLE, `cnt=0`, `pad_pending=0`.
- All outputs are registered or decoded from state only. There is no combinational path from `k_buffer_full` or `s_valid` to any output.
- Start latency: `s_valid` rises in IDLE -> `core_clear` the next cycle -> first byte accepted the cycle after.
- Throughput: 4 PACK cycles plus at least 1 SEND cycle per word, so 5 cycles per word with no stall.
- `k_buffer_full` may rise on any cycle, including the SEND_LAST cycle. The word is held and retried each cycle until a transfer occurs.
- `reset` mid-message: asynchronous return to reset values. A partially built word is discarded and nothing further is sent to the core. The source must restart the message.
- `k_out_ready` high outside WAIT_HASH is ignored. It is high before the next `core_clear` and must not produce `done`.
- Back-to-back messages: `s_valid` held high across DONE gives IDLE -> CLEAR on the cycle after DONE.

## Test plan
- "Hello, world!" (13 bytes) -> words 0x48656C6C, 0x6F2C2077, 0x6F726C64, then 0x21000000 with `is_last=1`, `byte_num=1`. One `core_clear` before the first word; `done` follows `k_out_ready`.
- "Hello, world" (12 bytes) -> three full words, then 0x00000000 with `is_last=1`, `byte_num=0`. Exactly four transfers.
- "The quick brown fox jumps over the lazy dog" (43 bytes) with `k_buffer_full` forced high for 5 cycles during word 5 -> `k_in` stable throughout the stall. Final word 0x646F6700 with `byte_num=3`, 11 transfers total, no word duplicated or lost.
- Single byte "A" -> CLEAR pulse, then one word 0x41000000 with `is_last=1` and `byte_num=1`. `busy` is high from CLEAR through DONE.
- Assert `reset` after 6 bytes of a message -> all outputs 0 within the same cycle and no further `k_in_ready`. A new 3-byte message "abc" then yields 0x61626300 with `byte_num=3` and a single `done`.
- Two messages back-to-back with `s_valid` held high -> two `core_clear` pulses, two `done` pulses. A stale `k_out_ready` during the second message's PACK does not trigger `done`.
